// File: rtl/mdu_if.sv
// Request/response bundle between the core and the multiply/divide unit.
// Request: in_valid/in_ready handshake carrying op, word, src1, src2, plus kill.
// Response: out_valid/out_ready handshake carrying result; busy while an op is held.
interface mdu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, word, src1, src2, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, src1, src2, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: N+1 cycles from accept to out_valid (N=64, or 32 for W ops); 1 cycle for div-by-zero/overflow.
// Backpressure: result and out_valid hold in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low), bus (mdu_if.slave: request, response, kill, busy).
module mdu (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q;
    logic [5:0]    cnt_q;
    logic [63:0]   result_q;
    logic          is_div_q, word_q, hi_q, rem_sel_q, neg_q;
    logic [63:0]   opa_q;          // multiplicand / dividend magnitude
    logic [63:0]   opb_q;          // multiplier / divisor magnitude
    logic [127:0]  acc_q;          // product accumulator
    logic [64:0]   prem_q;         // partial remainder
    logic [63:0]   quo_q;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Operand decode for the request currently presented
    logic        wd, s1, s2, a_neg, b_neg, div_zero, ovf;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, sp_raw, sp_res;

    always_comb begin
        wd       = bus.word && !(bus.op inside {3'd1, 3'd2, 3'd3});
        s1       = bus.op inside {3'd1, 3'd2, 3'd4, 3'd6};
        s2       = bus.op inside {3'd1, 3'd4, 3'd6};
        a_ext    = wd ? {{32{s1 & bus.src1[31]}}, bus.src1[31:0]} : bus.src1;
        b_ext    = wd ? {{32{s2 & bus.src2[31]}}, bus.src2[31:0]} : bus.src2;
        a_neg    = s1 & a_ext[63];
        b_neg    = s2 & b_ext[63];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = bus.op[2] && (b_ext == '0);
        // Signed DIV/REM of the most-negative value by -1
        ovf      = bus.op[2] && !bus.op[0] && (b_ext == '1) &&
                   (a_ext == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        sp_raw   = div_zero ? (bus.op[1] ? a_ext : '1) : (bus.op[1] ? '0 : a_ext);
        sp_res   = wd ? sext32(sp_raw[31:0]) : sp_raw;
    end

    // One iteration step, MSB first for both multiplier bits and dividend bits
    logic [127:0] mul_nxt, prod;
    logic [64:0]  rem_sh, rem_nxt;
    logic [63:0]  quo_nxt, quo_s, rem_s, raw, fin;
    logic         ge;

    always_comb begin
        mul_nxt = (acc_q << 1) + (opb_q[cnt_q] ? {64'd0, opa_q} : 128'd0);
        rem_sh  = (prem_q << 1) | {64'd0, opa_q[cnt_q]};
        ge      = rem_sh >= {1'b0, opb_q};
        rem_nxt = ge ? rem_sh - {1'b0, opb_q} : rem_sh;
        quo_nxt = (quo_q << 1) | {63'd0, ge};
        prod    = neg_q ? -mul_nxt : mul_nxt;
        quo_s   = neg_q ? -quo_nxt : quo_nxt;
        rem_s   = neg_q ? -rem_nxt[63:0] : rem_nxt[63:0];
        raw     = is_div_q ? (rem_sel_q ? rem_s : quo_s)
                           : (hi_q ? prod[127:64] : prod[63:0]);
        fin     = word_q ? sext32(raw[31:0]) : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            is_div_q  <= 1'b0;
            word_q    <= 1'b0;
            hi_q      <= 1'b0;
            rem_sel_q <= 1'b0;
            neg_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
        end else if (bus.kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        is_div_q  <= bus.op[2];
                        word_q    <= wd;
                        hi_q      <= bus.op[2:0] inside {3'd1, 3'd2, 3'd3};
                        rem_sel_q <= bus.op[1];
                        // Remainder takes the dividend's sign; everything else the XOR
                        neg_q     <= (bus.op[2] && bus.op[1]) ? a_neg : (a_neg ^ b_neg);
                        opa_q     <= a_mag;
                        opb_q     <= b_mag;
                        acc_q     <= '0;
                        prem_q    <= '0;
                        quo_q     <= '0;
                        if (div_zero || ovf) begin
                            result_q <= sp_res;
                            state_q  <= DONE;
                        end else begin
                            cnt_q   <= wd ? 6'd31 : 6'd63;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q  <= mul_nxt;
                    prem_q <= rem_nxt;
                    quo_q  <= quo_nxt;
                    cnt_q  <= cnt_q - 6'd1;
                    if (cnt_q == 6'd0) begin
                        result_q <= fin;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;
endmodule
